// File: rtl/npc_pkg.sv
// Shared types for the next-PC generator: 2-bit branch counters, BTB entry layout, PC step.
// Entry tag/target fields are XLEN wide; users zero-extend narrower tags into them.
package npc_pkg;

   localparam int XLEN    = 32;
   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] tag;
      logic [XLEN-1:0] target;
      ctr_t            ctr;
   } btb_entry_t;

   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB: combinational read port, one synchronous update port per cycle.
// Reads return pre-update contents when both ports hit the same index in a cycle.
module btb_table
   import npc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int IDXW  = $clog2(DEPTH),
   parameter int TAGW  = WIDTH - IDXW - 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDXW-1:0]  rd_idx,
   input  logic [TAGW-1:0]  rd_tag,
   output logic             rd_hit,
   output ctr_t             rd_ctr,
   output logic [WIDTH-1:0] rd_target,
   input  logic             wr_en,
   input  logic [IDXW-1:0]  wr_idx,
   input  logic [TAGW-1:0]  wr_tag,
   input  logic             wr_taken,
   input  logic [WIDTH-1:0] wr_target
);

   btb_entry_t mem [DEPTH];
   btb_entry_t rd_ent;
   logic       wr_hit;

   assign rd_ent    = mem[rd_idx];
   assign rd_hit    = rd_ent.valid && (rd_ent.tag == XLEN'(rd_tag));
   assign rd_ctr    = rd_ent.ctr;
   assign rd_target = rd_ent.target[WIDTH-1:0];

   assign wr_hit = mem[wr_idx].valid && (mem[wr_idx].tag == XLEN'(wr_tag));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         if (wr_taken) begin
            if (wr_hit) begin
               mem[wr_idx].target <= XLEN'(wr_target);
               mem[wr_idx].ctr    <= ctr_inc(mem[wr_idx].ctr);
            end else begin
               // A taken miss evicts whatever aliased into this slot.
               mem[wr_idx] <= '{valid: 1'b1, tag: XLEN'(wr_tag),
                                target: XLEN'(wr_target), ctr: CTR_WT};
            end
         end else if (wr_hit) begin
            mem[wr_idx].ctr <= ctr_dec(mem[wr_idx].ctr);
         end
      end
   end

endmodule

// File: rtl/npc_btb.sv
// Fetch PC register with BTB prediction (0-cycle) and EX-driven redirect (1 edge after flush).
// stall holds pc, but a mispredict redirect always wins over stall.
module npc_btb
   import npc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               BTB_DEPTH = 16,
   parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_pc,
   input  logic             res_taken,
   input  logic [WIDTH-1:0] res_target,
   input  logic             res_pred_taken,
   input  logic [WIDTH-1:0] res_pred_target,
   output logic [WIDTH-1:0] pc,
   output logic             pred_taken,
   output logic [WIDTH-1:0] pred_target,
   output logic             flush
);

   localparam int IDXW = $clog2(BTB_DEPTH);

   logic             hit;
   ctr_t             ctr;
   logic [WIDTH-1:0] btb_target;
   logic             mis;
   logic [WIDTH-1:0] pc_next;

   btb_table #(
      .WIDTH (WIDTH),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc[IDXW+1:2]),
      .rd_tag    (pc[WIDTH-1:IDXW+2]),
      .rd_hit    (hit),
      .rd_ctr    (ctr),
      .rd_target (btb_target),
      .wr_en     (res_valid),
      .wr_idx    (res_pc[IDXW+1:2]),
      .wr_tag    (res_pc[WIDTH-1:IDXW+2]),
      .wr_taken  (res_taken),
      .wr_target (res_target)
   );

   assign pred_taken  = hit && (ctr == CTR_WT || ctr == CTR_ST);
   assign pred_target = pred_taken ? btb_target : '0;

   assign mis   = res_valid && ((res_taken != res_pred_taken) ||
                                (res_taken && (res_target != res_pred_target)));
   assign flush = mis;

   always_comb begin
      pc_next = pc + WIDTH'(PC_STEP);
      if (mis) begin
         pc_next = res_taken ? res_target : res_pc + WIDTH'(PC_STEP);
      end else if (stall) begin
         pc_next = pc;
      end else if (pred_taken) begin
         pc_next = pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: tb/tb_npc_btb.sv
// Bench for npc_btb: directed vector table, a counter-saturation sequence, then random traffic vs a model.
module tb_npc_btb;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, res_valid, res_taken, res_pred_taken;
   logic [31:0] res_pc, res_target, res_pred_target;
   logic [31:0] pc, pred_target;
   logic        pred_taken, flush;

   npc_btb #(
      .WIDTH     (32),
      .BTB_DEPTH (16),
      .RESET_PC  (32'h0000_3000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .res_valid       (res_valid),
      .res_pc          (res_pc),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .res_pred_taken  (res_pred_taken),
      .res_pred_target (res_pred_target),
      .pc              (pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .flush           (flush)
   );

   typedef struct {
      logic        rst, stall, rv;
      logic [31:0] rpc;
      logic        rt;
      logic [31:0] rtgt;
      logic        rpt;
      logic [31:0] rptgt;
   } in_t;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   vec_t tbl[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;

   // Reference model: a 16-slot table indexed by word address mod 16, tag = pc/64.
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      else
         passed++;
   endtask

   task automatic model_lookup(output logic o_pt, output logic [31:0] o_ptgt);
      int idx;
      bit hit;
      idx    = int'((m_pc / 4) % 16);
      hit    = m_valid[idx] && (m_tag[idx] == m_pc / 64);
      o_pt   = hit && (m_ctr[idx] >= 2);
      o_ptgt = o_pt ? m_tgt[idx] : 32'd0;
   endtask

   function automatic logic model_mis(input in_t i);
      return i.rv && ((i.rt != i.rpt) || (i.rt && i.rtgt != i.rptgt));
   endfunction

   task automatic model_step(input in_t i);
      logic        pt;
      logic [31:0] ptgt;
      int          u;
      bit          uhit;
      model_lookup(pt, ptgt);
      if (i.rst) begin
         m_pc = 32'h3000;
         for (int k = 0; k < 16; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 0;
         end
         return;
      end
      if (model_mis(i))   m_pc = i.rt ? i.rtgt : i.rpc + 32'd4;
      else if (i.stall)   m_pc = m_pc;
      else if (pt)        m_pc = ptgt;
      else                m_pc = m_pc + 32'd4;
      if (i.rv) begin
         u    = int'((i.rpc / 4) % 16);
         uhit = m_valid[u] && (m_tag[u] == i.rpc / 64);
         if (i.rt && uhit) begin
            m_tgt[u] = i.rtgt;
            m_ctr[u] = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
         end else if (i.rt) begin
            m_valid[u] = 1; m_tag[u] = i.rpc / 64; m_tgt[u] = i.rtgt; m_ctr[u] = 2;
         end else if (uhit) begin
            m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
         end
      end
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; stall = i.stall; res_valid = i.rv; res_pc = i.rpc;
      res_taken = i.rt; res_target = i.rtgt; res_pred_taken = i.rpt; res_pred_target = i.rptgt;
   endtask

   // One clock: drive, compare on the falling edge, advance the model, step past the rising edge.
   task automatic run_cycle(input in_t i, input bit use_tbl, input exp_t e);
      exp_t ex;
      drive(i);
      @(negedge clk);
      if (use_tbl) begin
         ex = e;
      end else begin
         ex.pc = m_pc;
         model_lookup(ex.pt, ex.ptgt);
         ex.fl = model_mis(i);
      end
      check("pc",          pc,                  ex.pc);
      check("pred_taken",  {31'd0, pred_taken}, {31'd0, ex.pt});
      check("pred_target", pred_target,         ex.ptgt);
      check("flush",       {31'd0, flush},      {31'd0, ex.fl});
      model_step(i);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic row(input logic r, input logic s, input logic v, input logic [31:0] rpc,
                      input logic t, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                      input logic [31:0] epc, input logic ept, input logic [31:0] eptgt, input logic efl);
      vec_t x;
      x.i = '{r, s, v, rpc, t, tgt, pt, ptgt};
      x.e = '{epc, ept, eptgt, efl};
      tbl.push_back(x);
   endtask

   task automatic res(input logic [31:0] rpc, input logic t, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt);
      in_t x;
      x = '{1'b0, 1'b0, 1'b1, rpc, t, tgt, pt, ptgt};
      run_cycle(x, 1'b0, '{0, 0, 0, 0});
   endtask

   initial begin
      in_t  z, r;
      exp_t dummy;
      z     = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
      dummy = '{32'd0, 1'b0, 32'd0, 1'b0};
      r     = z;
      r.rst = 1'b1;
      drive(r);
      model_step(r);
      @(posedge clk);
      #1;

      //   rst stall rv  res_pc        tk  target        ptk ptarget       | pc            pt  ptgt          fl
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3000,     0, 32'h0,        0);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3004,     0, 32'h0,        0);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3008,     0, 32'h0,        0);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h300C,     0, 32'h0,        0);
      row(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3010,     0, 32'h0,        0);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3000,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3004,     1, 32'h3100,     0, 32'h0,          32'h3004,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3100,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3000,     0, 32'h0,        1, 32'h1234,       32'h3104,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3004,     1, 32'h3100,     0);
      row(0, 0, 1, 32'h3004,     1, 32'h3100,     1, 32'h3100,       32'h3100,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3004,     1, 32'h3100,     1, 32'h3100,       32'h3104,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3004,     0, 32'h0,        0, 32'h0,          32'h3108,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3000,     0, 32'h0,        1, 32'h1234,       32'h310C,     0, 32'h0,        1);
      row(0, 0, 1, 32'h3004,     0, 32'h0,        0, 32'h0,          32'h3004,     1, 32'h3100,     0);
      row(0, 0, 1, 32'h3000,     0, 32'h0,        1, 32'h1234,       32'h3100,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3004,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3044,     1, 32'h3200,     0, 32'h0,          32'h3008,     0, 32'h0,        1);
      row(0, 0, 1, 32'h3000,     0, 32'h0,        1, 32'h1234,       32'h3200,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3004,     0, 32'h0,        0);
      row(0, 0, 1, 32'h3040,     0, 32'h0,        1, 32'h1234,       32'h3008,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3044,     1, 32'h3200,     0);
      row(0, 1, 1, 32'h3008,     0, 32'h0,        1, 32'h3300,       32'h3200,     0, 32'h0,        1);
      row(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h300C,     0, 32'h0,        0);
      row(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h300C,     0, 32'h0,        0);
      row(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h300C,     0, 32'h0,        0);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h300C,     0, 32'h0,        0);
      row(0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,          32'h3010,     0, 32'h0,        1);
      row(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'hFFFFFFFC,   32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h00000000, 0, 32'h0,        0);
      row(0, 0, 1, 32'hFFFFFFF8, 0, 32'h0,        1, 32'h1234,       32'h00000004, 0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'hFFFFFFFC, 0, 32'h0,        0);
      row(1, 1, 1, 32'h3044,     1, 32'h5000,     0, 32'h0,          32'h00000000, 0, 32'h0,        1);
      row(0, 0, 1, 32'h3040,     0, 32'h0,        1, 32'h1234,       32'h3000,     0, 32'h0,        1);
      row(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,          32'h3044,     0, 32'h0,        0);

      foreach (tbl[k]) run_cycle(tbl[k].i, 1'b1, tbl[k].e);

      // Saturation both ways, then a taken hit on a 00 counter must increment, not reallocate.
      for (int k = 0; k < 4; k++) res(32'h3080, 1'b1, 32'h3400, 1'b1, 32'h3400);
      for (int k = 0; k < 4; k++) res(32'h3080, 1'b0, 32'h0,    1'b0, 32'h0);
      res(32'h3080, 1'b1, 32'h3400, 1'b1, 32'h3400);
      res(32'h307C, 1'b0, 32'h0, 1'b1, 32'h3400);
      run_cycle(z, 1'b0, dummy);
      check("ctr01_not_taken", {31'd0, pred_taken}, 32'd0);

      for (int n = 0; n < 600; n++) begin
         r.rst   = ($urandom_range(0, 99) == 0);
         r.stall = ($urandom_range(0, 5) == 0);
         r.rv    = ($urandom_range(0, 2) != 0);
         r.rpc   = ($urandom_range(0, 3) == 0) ? m_pc : 32'h3000 + ($urandom_range(0, 31) << 2);
         r.rt    = $urandom_range(0, 1);
         r.rtgt  = 32'h3000 + ($urandom_range(0, 63) << 2);
         r.rpt   = $urandom_range(0, 1);
         r.rptgt = ($urandom_range(0, 1) == 0) ? r.rtgt : 32'h3000 + ($urandom_range(0, 63) << 2);
         run_cycle(r, 1'b0, dummy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/npc_btb.md
Name: npc_btb

Overview:
- Registered next-PC generator for the pipelined datapath fetch stage.
- Holds the architectural fetch PC and predicts the next PC through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts branch/jump resolution from EX and redirects fetch on a mispredict.
- Supersedes the combinational single-cycle NPC: target arithmetic now lives in EX; this block owns PC sequencing and prediction.

Parameters:
- WIDTH, 32, PC/target width in bits.
- BTB_DEPTH, 16, BTB entries; power of two, at least 2.
- RESET_PC, 32'h0000_3000, PC value loaded by reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold PC (fetch/decode back-pressure).
- res_valid  in  1  EX resolves a control-flow instruction this cycle.
- res_pc  in  WIDTH  PC of the resolved instruction.
- res_taken  in  1  actual outcome (jumps are always 1).
- res_target  in  WIDTH  actual taken target.
- res_pred_taken  in  1  prediction carried down the pipe with that instruction.
- res_pred_target  in  WIDTH  predicted target carried down the pipe.
- pc  out  WIDTH  current fetch PC (register).
- pred_taken  out  1  prediction for pc (combinational from the BTB).
- pred_target  out  WIDTH  predicted target for pc; 0 when pred_taken=0.
- flush  out  1  squash younger instructions in IF/ID (combinational).

Behaviour:
- Reset:
  - pc=RESET_PC.
  - All BTB valid bits and counters are 0, so pred_taken=0, pred_target=0 and flush=0 after reset.
  - Reset asserted mid-operation overrides stall and resolution in the same cycle.
- Indexing:
  - idx = pc[log2(BTB_DEPTH)+1:2].
  - tag = pc[WIDTH-1:log2(BTB_DEPTH)+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[WIDTH-1:0], ctr[1:0].
- Lookup:
  - hit = valid && (tag match).
  - pred_taken = hit && ctr[1].
- Mispredict:
  - mis = res_valid && ((res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target)).
  - flush = mis.
- Next-PC priority, evaluated every cycle:
  - rst gives RESET_PC.
  - Otherwise mis gives (res_taken ? res_target : res_pc+4). A redirect overrides stall.
  - Otherwise stall holds pc.
  - Otherwise pred_taken gives pred_target.
  - Otherwise pc+4.
  - All additions are modulo 2^WIDTH; wrap-around is legal and is not flagged.
- BTB update on res_valid (independent of stall and mis), at the entry indexed by res_pc:
  - Taken and hit: target=res_target; ctr saturating-increment (3 stays 3).
  - Taken and miss: allocate (overwriting any prior occupant); valid=1, tag, target=res_target, ctr=2'b10.
  - Not taken and hit: ctr saturating-decrement (0 stays 0); the entry stays valid.
  - Not taken and miss: no change.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Same-cycle update and lookup of the same index: the lookup sees pre-update contents (read-before-write); the update is visible in the next cycle.
- Latency:
  - Prediction: 0 cycles (same cycle as pc).
  - Redirect: pc takes the corrected value one edge after mis.
- One resolution per cycle; there are no simultaneous-update conflicts.

Decomposition:
- Package npc_pkg holds:
  - Counter encodings and their saturating inc/dec functions.
  - The BTB entry struct typedef.
  - The PC_STEP=4 constant.
- Sub-module btb_table holds:
  - The entry array with its valid bits.
  - The combinational read port and the synchronous update port.
- npc_btb holds the PC register, the mispredict compare and the next-PC mux.

Test Plan (BTB_DEPTH=16, RESET_PC=32'h3000):
- Reset, then 4 free-running cycles, then rst=1 for one cycle -> pc sequence 3000,3004,3008,300C,3010, then 3000 after the reset edge; flush=0 throughout.
- Resolve res_pc=3004, taken to 3100, pred_taken=0 -> flush=1 that cycle; next pc=3100. Later fetch of 3004 -> pred_taken=1, pred_target=3100, next pc=3100.
- Train 3004 to strong-T (two taken resolutions), then one not-taken resolution -> 3004 still predicted taken (ctr=10). A second not-taken -> predicted not-taken, pc 3004→3008.
- Aliasing: entry for 3004 allocated, then res_pc=3044 taken to 3200 (same idx, new tag) -> fetch of 3004 misses (pc+4); fetch of 3044 predicts 3200.
- stall=1 with a mispredict (res_pc=3008, not taken, pred_taken=1) in the same cycle -> pc=300C next edge despite stall. With stall=1 and no mispredict, pc holds for 3 cycles.
- res_pc=FFFFFFFC, not-taken mispredict (res_pred_taken=1) -> flush=1, next pc=00000000 (wrap); same-cycle lookup at the updated index returns the old entry.
